fir_tap_sequencer: RTL and testbench
====================================

// Module: fir_tap_sequencer
// PURPOSE
//  Controls the 64-entry coefficient SRAM of the 64-tap 16-bit FIR.
//  Two jobs: streams host coefficients into the SRAM (LOAD), and, for each
//  accepted input sample, sweeps tap addresses 0..NTAPS-1 (RUN).
//  During RUN it emits aligned MAC strobes (enable/first/last/tap index) that
//  account for the SRAM's 1-cycle registered read.
//  Sits between the host config port / sample input and the SRAM + MAC datapath.
// PARAMETERS
//  NTAPS  64  number of taps = coefficient SRAM depth
//  AW     6   address width, clog2(NTAPS)
//  DW     16  coefficient data width
// PORTS
//  clk           in   1   single clock, all logic on posedge
//  rst_n         in   1   synchronous reset, active-low
//  cfg_start     in   1   pulse: begin a full coefficient load
//  cfg_valid     in   1   cfg_data valid
//  cfg_data      in   DW  coefficient value; taps are written in order 0..NTAPS-1
//  cfg_ready     out  1   controller accepts a coefficient
//  load_done     out  1   1-cycle pulse after the last coefficient write
//  coef_loaded   out  1   SRAM holds a complete coefficient set
//  sample_valid  in   1   new input sample present
//  sample_ready  out  1   controller accepts a sample (starts a sweep)
//  cm_addr       out  AW  SRAM address (registered)
//  cm_w_en       out  1   SRAM write enable (registered)
//  cm_data_in    out  DW  SRAM write data (registered)
//  mac_en        out  1   SRAM data_out holds a valid coefficient this cycle
//  mac_first     out  1   qualifies tap 0: MAC clears its accumulator
//  mac_last      out  1   qualifies tap NTAPS-1: result complete after this cycle
//  mac_tap       out  AW  tap index of the coefficient currently on SRAM data_out
//  busy          out  1   state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, tap counter=0, coef_loaded=0.
//   All registered outputs go to 0.
//   Reset at any time, including mid-LOAD or mid-RUN, aborts the operation
//   with no further writes or strobes.
//  States: IDLE, LOAD, RUN, DRAIN.
//  IDLE: cfg_ready=0; sample_ready = coef_loaded & ~cfg_start.
//   cfg_start=1 -> LOAD, counter=0. cfg_start has priority over sample_valid.
//   sample_valid & sample_ready -> RUN, counter=0.
//  LOAD: cfg_ready=1, sample_ready=0; cfg_start ignored.
//   Each cfg_valid&cfg_ready handshake at cycle t: at t+1, cm_w_en=1,
//   cm_addr=counter, cm_data_in=cfg_data; then the counter increments.
//   Cycles without cfg_valid: cm_w_en=0, counter holds.
//   On the handshake with counter==NTAPS-1: coef_loaded=1, load_done=1 at t+1,
//   state -> IDLE at t+1.
//   coef_loaded=0 from the cycle after LOAD is entered until completion.
//  RUN: cm_w_en=0, cfg_ready=0, sample_ready=0.
//   Sample accepted at cycle t: cm_addr = 0,1,..,NTAPS-1 on cycles t+1..t+NTAPS.
//   After cm_addr=NTAPS-1 is issued -> DRAIN.
//  DRAIN: one cycle, then -> IDLE.
//  MAC strobes: registered copy of the read-issue flag and address, delayed 1 cycle.
//   mac_en=1 on cycles t+2..t+NTAPS+1, with mac_tap=0..NTAPS-1.
//   mac_first=1 only at t+2; mac_last=1 only at t+NTAPS+1.
//  Throughput: next sample accepted no earlier than t+NTAPS+2 (IDLE after DRAIN).
//  Counter: AW bits. Terminal compare is against NTAPS-1, so it never wraps
//   past the last tap.
//  cm_addr holds its last value when idle; cm_w_en=0 outside LOAD writes.
// STRUCTURE
//  Shared package fir_pkg: NTAPS, AW, DW constants and the state enum
//   (IDLE/LOAD/RUN/DRAIN).
//   The SRAM and the MAC import the same constants.
//  One sub-module: fir_tap_counter (AW-bit counter with clear, increment enable
//   and terminal flag at NTAPS-1).
//  FSM and strobe-delay registers stay in this module.
// TESTING
//  1 Load: cfg_start, then 64 coefficients 0x0100+i, with cfg_valid low every
//    3rd cycle -> 64 writes, cm_addr=i, cm_data_in=0x0100+i;
//    load_done pulses once; coef_loaded=1.
//  2 Sample before any load: sample_valid=1 for 10 cycles after reset ->
//    sample_ready=0, no cm_addr change, mac_en never asserted.
//  3 Single sweep after load: sample at cycle t ->
//    cm_addr 0..63 on t+1..t+64; mac_en t+2..t+65;
//    mac_first at t+2; mac_last at t+65 with mac_tap=63; mac_tap matches SRAM data.
//  4 Back-to-back: sample_valid held high -> accepts at t, t+66, t+132;
//    no gap or overlap in mac strobes.
//  5 Reset mid-LOAD after 20 writes, then mid-RUN at tap 30 ->
//    all outputs 0 next cycle; coef_loaded=0; a new sample is refused until a full reload.
//  6 cfg_start and sample_valid in the same IDLE cycle -> LOAD entered;
//    sample not accepted; sample_ready=0 throughout LOAD.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the 64-tap, 16-bit FIR coefficient path.
// The coefficient SRAM and the MAC import the same package so their widths stay in step.
package fir_pkg;

    localparam int NTAPS = 64;
    localparam int AW    = $clog2(NTAPS);
    localparam int DW    = 16;

    localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN
    } seq_state_t;

    function automatic logic is_last_tap(input logic [AW-1:0] tap);
        return tap == LAST_TAP;
    endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Host config, sample handshake, coefficient SRAM port and MAC strobes of the tap sequencer.
// The master side is the host/datapath environment; the slave side is the sequencer itself.
interface fir_tap_sequencer_if;
    import fir_pkg::*;

    logic          cfg_start;
    logic          cfg_valid;
    logic [DW-1:0] cfg_data;
    logic          cfg_ready;
    logic          load_done;
    logic          coef_loaded;
    logic          sample_valid;
    logic          sample_ready;
    logic [AW-1:0] cm_addr;
    logic          cm_w_en;
    logic [DW-1:0] cm_data_in;
    logic          mac_en;
    logic          mac_first;
    logic          mac_last;
    logic [AW-1:0] mac_tap;
    logic          busy;

    modport master (
        output cfg_start, cfg_valid, cfg_data, sample_valid,
        input  cfg_ready, load_done, coef_loaded, sample_ready,
        input  cm_addr, cm_w_en, cm_data_in,
        input  mac_en, mac_first, mac_last, mac_tap, busy
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, sample_valid,
        output cfg_ready, load_done, coef_loaded, sample_ready,
        output cm_addr, cm_w_en, cm_data_in,
        output mac_en, mac_first, mac_last, mac_tap, busy
    );

endinterface

// File: rtl/fir_tap_counter.sv
// Tap index counter: clears to 0, advances on inc and saturates at the last tap,
// so a sweep or load can never wrap back onto tap 0.
module fir_tap_counter
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          inc,
    output logic [AW-1:0] count,
    output logic          terminal
);

    assign terminal = is_last_tap(count);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !terminal) begin
            count <= count + AW'(1);
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Coefficient SRAM controller for the FIR: streams host coefficients into the SRAM and,
// per accepted sample, sweeps taps 0..NTAPS-1 with MAC strobes aligned to the 1-cycle read.
module fir_tap_sequencer
    import fir_pkg::*;
(
    input logic                clk,
    input logic                rst_n,
    fir_tap_sequencer_if.slave bus
);

    seq_state_t    state;
    logic          rd_issue;
    logic          cnt_clear;
    logic          cnt_inc;
    logic [AW-1:0] cnt;
    logic          cnt_last;
    logic          cfg_hs;
    logic          sample_hs;

    fir_tap_counter u_tap_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .inc      (cnt_inc),
        .count    (cnt),
        .terminal (cnt_last)
    );

    // A pending cfg_start blocks sample acceptance so a reload always wins the tie.
    assign bus.cfg_ready    = (state == LOAD);
    assign bus.sample_ready = (state == IDLE) && bus.coef_loaded && !bus.cfg_start;
    assign bus.busy         = (state != IDLE);

    assign cfg_hs    = bus.cfg_valid && bus.cfg_ready;
    assign sample_hs = bus.sample_valid && bus.sample_ready;

    always_comb begin
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_clear = bus.cfg_start || sample_hs;
            end
            LOAD: begin
                cnt_clear = cfg_hs && cnt_last;
                cnt_inc   = cfg_hs && !cnt_last;
            end
            RUN: begin
                cnt_inc = !cnt_last;
            end
            default: begin
            end
        endcase
    end

    // During RUN the counter always equals the address on cm_addr, so the next
    // read address is count+1; the MAC strobes trail the read issue by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            rd_issue        <= 1'b0;
            bus.coef_loaded <= 1'b0;
            bus.load_done   <= 1'b0;
            bus.cm_addr     <= '0;
            bus.cm_w_en     <= 1'b0;
            bus.cm_data_in  <= '0;
            bus.mac_en      <= 1'b0;
            bus.mac_first   <= 1'b0;
            bus.mac_last    <= 1'b0;
            bus.mac_tap     <= '0;
        end else begin
            bus.load_done <= 1'b0;
            bus.cm_w_en   <= 1'b0;
            bus.mac_en    <= rd_issue;
            bus.mac_first <= rd_issue && (bus.cm_addr == '0);
            bus.mac_last  <= rd_issue && is_last_tap(bus.cm_addr);
            if (rd_issue) begin
                bus.mac_tap <= bus.cm_addr;
            end

            case (state)
                IDLE: begin
                    if (bus.cfg_start) begin
                        state           <= LOAD;
                        bus.coef_loaded <= 1'b0;
                    end else if (sample_hs) begin
                        state       <= RUN;
                        rd_issue    <= 1'b1;
                        bus.cm_addr <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_hs) begin
                        bus.cm_w_en    <= 1'b1;
                        bus.cm_addr    <= cnt;
                        bus.cm_data_in <= bus.cfg_data;
                        if (cnt_last) begin
                            state           <= IDLE;
                            bus.coef_loaded <= 1'b1;
                            bus.load_done   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cnt_last) begin
                        state    <= DRAIN;
                        rd_issue <= 1'b0;
                    end else begin
                        bus.cm_addr <= cnt + AW'(1);
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: a small behavioural model predicts handshakes,
// SRAM writes, read addresses and MAC strobes, which a scoreboard checks cycle by cycle.
module tb_fir_tap_sequencer;
    import fir_pkg::*;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] tap;
    } tap_exp_t;

    logic clk = 1'b0;
    logic rst_n;

    fir_tap_sequencer_if bus();

    fir_tap_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM with a registered read, used to prove mac_tap lines up with data_out.
    logic [DW-1:0] sram [NTAPS];
    logic [DW-1:0] sram_q;

    always @(posedge clk) begin
        if (bus.cm_w_en === 1'b1) sram[bus.cm_addr] <= bus.cm_data_in;
        sram_q <= sram[bus.cm_addr];
    end

    wr_exp_t    wr_q [$];
    tap_exp_t   rd_q [$];
    tap_exp_t   mac_q [$];
    wr_exp_t    mon_w;
    tap_exp_t   mon_t;

    seq_state_t    m_state   = IDLE;
    logic          m_loaded  = 1'b0;
    int            m_idx     = 0;
    int            m_run_end = 0;
    logic [AW-1:0] m_addr    = '0;
    int            done_cyc  = -1;
    int            done_seen = 0;
    int            accepts   = 0;
    int            last_accept = 0;
    bit            mon_on    = 1'b0;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock of stimulus: drive at posedge+1, check and advance the model at negedge.
    task automatic apply_stimulus(input logic cs, input logic cv, input logic [DW-1:0] cd,
                                  input logic sv);
        bus.cfg_start    = cs;
        bus.cfg_valid    = cv;
        bus.cfg_data     = cd;
        bus.sample_valid = sv;
        @(negedge clk);
        check_output("cfg_ready", 32'(bus.cfg_ready), 32'(m_state == LOAD));
        check_output("sample_ready", 32'(bus.sample_ready),
                     32'((m_state == IDLE) && m_loaded && !cs));
        check_output("busy", 32'(bus.busy), 32'(m_state != IDLE));
        check_output("coef_loaded", 32'(bus.coef_loaded), 32'(m_loaded));
        case (m_state)
            IDLE: begin
                if (cs) begin
                    m_state  = LOAD;
                    m_idx    = 0;
                    m_loaded = 1'b0;
                end else if (sv && m_loaded) begin
                    last_accept = cyc;
                    accepts++;
                    for (int i = 0; i < NTAPS; i++) begin
                        rd_q.push_back('{cyc: cyc + 1 + i, tap: AW'(i)});
                        mac_q.push_back('{cyc: cyc + 2 + i, tap: AW'(i)});
                    end
                    m_state   = RUN;
                    m_run_end = cyc + NTAPS + 2;
                end
            end
            LOAD: begin
                if (cv) begin
                    wr_q.push_back('{cyc: cyc + 1, addr: AW'(m_idx), data: cd});
                    if (m_idx == NTAPS - 1) begin
                        m_loaded = 1'b1;
                        done_cyc = cyc + 1;
                        m_state  = IDLE;
                    end else begin
                        m_idx++;
                    end
                end
            end
            default: begin
                if (cyc + 1 >= m_run_end) m_state = IDLE;
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.cfg_start    = 1'b0;
        bus.cfg_valid    = 1'b0;
        bus.cfg_data     = '0;
        bus.sample_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_q.delete();
        rd_q.delete();
        mac_q.delete();
        m_state  = IDLE;
        m_loaded = 1'b0;
        m_idx    = 0;
        m_addr   = '0;
        done_cyc = -1;
        check_output("rst_cm_addr", 32'(bus.cm_addr), 32'(0));
        check_output("rst_cm_w_en", 32'(bus.cm_w_en), 32'(0));
        check_output("rst_cm_data_in", 32'(bus.cm_data_in), 32'(0));
        check_output("rst_mac_en", 32'(bus.mac_en), 32'(0));
        check_output("rst_mac_first", 32'(bus.mac_first), 32'(0));
        check_output("rst_mac_last", 32'(bus.mac_last), 32'(0));
        check_output("rst_mac_tap", 32'(bus.mac_tap), 32'(0));
        check_output("rst_load_done", 32'(bus.load_done), 32'(0));
        check_output("rst_coef_loaded", 32'(bus.coef_loaded), 32'(0));
        check_output("rst_busy", 32'(bus.busy), 32'(0));
        check_output("rst_sample_ready", 32'(bus.sample_ready), 32'(0));
    endtask

    // cfg_start, then n_writes coefficients 0x0100+i with cfg_valid low every 3rd cycle.
    task automatic load_coefs(input logic sv, input int n_writes);
        int writes;
        writes = 0;
        apply_stimulus(1'b1, 1'b0, '0, sv);
        for (int k = 0; k < 4 * NTAPS && writes < n_writes; k++) begin
            logic cv;
            cv = (k % 3) != 2;
            apply_stimulus(1'b0, cv, DW'(16'h0100 + m_idx), sv);
            if (cv) writes++;
        end
        check_output("load_writes", 32'(writes), 32'(n_writes));
    endtask

    task automatic run_samples(input int n);
        int target;
        target = accepts + n;
        for (int k = 0; k < (NTAPS + 8) * n && accepts < target; k++) begin
            apply_stimulus(1'b0, 1'b0, '0, 1'b1);
        end
        check_output("accept_count", 32'(accepts), 32'(target));
        for (int k = 0; k < NTAPS + 8 && (m_state != IDLE || mac_q.size() > 0); k++) begin
            apply_stimulus(1'b0, 1'b0, '0, 1'b0);
        end
        check_output("sweep_drained", 32'(mac_q.size()), 32'(0));
    endtask

    // Scoreboard: every cycle compares writes, read addresses and MAC strobes against the queues.
    always @(negedge clk) begin
        if (mon_on) begin
            if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
                mon_w = wr_q.pop_front();
                check_output("cm_w_en", 32'(bus.cm_w_en), 32'(1));
                check_output("cm_addr_wr", 32'(bus.cm_addr), 32'(mon_w.addr));
                check_output("cm_data_in", 32'(bus.cm_data_in), 32'(mon_w.data));
                m_addr = mon_w.addr;
            end else begin
                check_output("cm_w_en", 32'(bus.cm_w_en), 32'(0));
                if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                    mon_t = rd_q.pop_front();
                    check_output("cm_addr_rd", 32'(bus.cm_addr), 32'(mon_t.tap));
                    m_addr = mon_t.tap;
                end else begin
                    check_output("cm_addr_hold", 32'(bus.cm_addr), 32'(m_addr));
                end
            end
            if (mac_q.size() > 0 && mac_q[0].cyc == cyc) begin
                mon_t = mac_q.pop_front();
                check_output("mac_en", 32'(bus.mac_en), 32'(1));
                check_output("mac_tap", 32'(bus.mac_tap), 32'(mon_t.tap));
                check_output("mac_first", 32'(bus.mac_first), 32'(mon_t.tap == '0));
                check_output("mac_last", 32'(bus.mac_last), 32'(mon_t.tap == AW'(NTAPS - 1)));
                check_output("mac_coef", 32'(sram_q), 32'(16'h0100) + 32'(mon_t.tap));
            end else begin
                check_output("mac_en_idle", 32'(bus.mac_en), 32'(0));
                check_output("mac_first_idle", 32'(bus.mac_first), 32'(0));
                check_output("mac_last_idle", 32'(bus.mac_last), 32'(0));
            end
            check_output("load_done", 32'(bus.load_done), 32'(done_cyc == cyc));
            if (bus.load_done === 1'b1) done_seen++;
        end
    end

    initial begin
        int done_before;
        int t_reset;

        rst_n            = 1'b0;
        bus.cfg_start    = 1'b0;
        bus.cfg_valid    = 1'b0;
        bus.cfg_data     = '0;
        bus.sample_valid = 1'b0;

        $display("[TB] reset state");
        do_reset();
        mon_on = 1'b1;

        $display("[TB] sample before any load is refused");
        for (int k = 0; k < 10; k++) apply_stimulus(1'b0, 1'b0, '0, 1'b1);

        $display("[TB] full coefficient load with gaps");
        done_before = done_seen;
        load_coefs(1'b0, NTAPS);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0);
        check_output("load_done_pulses", 32'(done_seen - done_before), 32'(1));
        check_output("coef_loaded_after_load", 32'(bus.coef_loaded), 32'(1));

        $display("[TB] single sweep");
        run_samples(1);

        $display("[TB] back-to-back sweeps with sample_valid held high");
        run_samples(3);

        $display("[TB] cfg_start and sample_valid in the same idle cycle");
        done_before = done_seen;
        load_coefs(1'b1, NTAPS);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0);
        check_output("reload_done_pulses", 32'(done_seen - done_before), 32'(1));
        run_samples(1);

        $display("[TB] reset in the middle of a load");
        load_coefs(1'b0, 20);
        do_reset();
        for (int k = 0; k < 5; k++) apply_stimulus(1'b0, 1'b0, '0, 1'b1);

        $display("[TB] reload, then reset in the middle of a sweep");
        load_coefs(1'b0, NTAPS);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0);
        t_reset = accepts + 1;
        for (int k = 0; k < 10 && accepts < t_reset; k++) apply_stimulus(1'b0, 1'b0, '0, 1'b1);
        check_output("run_accept", 32'(accepts), 32'(t_reset));
        for (int k = 0; k < NTAPS && cyc < last_accept + 31; k++) begin
            apply_stimulus(1'b0, 1'b0, '0, 1'b0);
        end
        check_output("reset_point_cycle", 32'(cyc), 32'(last_accept + 31));
        do_reset();
        for (int k = 0; k < 5; k++) apply_stimulus(1'b0, 1'b0, '0, 1'b1);
        check_output("no_accept_after_reset", 32'(accepts), 32'(t_reset));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
